branch_resolver: RTL
====================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight prediction entries (power of two, 2..16).
REQ-002 Parameter AW, default 32, instruction address width.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 rdy  input  1  global enable; when low, all state and outputs hold.
REQ-006 if_valid  input  1  fetch presents a control-flow instruction with its prediction.
REQ-007 if_pc  input  AW  address of that instruction.
REQ-008 if_jmp_e  input  1  predictor said taken.
REQ-009 if_pred  input  AW  predicted target.
REQ-010 if_ready  output  1  entry can be accepted this cycle.
REQ-011 ex_valid  input  1  execute resolves the oldest outstanding control-flow instruction.
REQ-012 ex_pc  input  AW  address of the resolved instruction.
REQ-013 ex_taken  input  1  actual direction.
REQ-014 ex_target  input  AW  actual taken target.
REQ-015 upd_jmp_r  output  1  one-cycle predictor-update strobe.
REQ-016 upd_addr_r  output  AW  address of the resolved branch.
REQ-017 upd_change_e  output  1  1 = taken (train up), 0 = not taken (train down).
REQ-018 upd_target_addr  output  AW  actual taken target (ex_target).
REQ-019 upd_target_real  output  AW  correct next PC.
REQ-020 flush  output  1  one-cycle mispredict strobe to fetch/decode.
REQ-021 redirect_pc  output  AW  correct next PC, valid while flush=1.
REQ-022 err  output  1  sticky protocol-error flag.
REQ-023 miss_cnt  output  32  count of mispredicts, wraps at 2^32.

Function
REQ-024 Entries SHALL be held in a circular FIFO {pc, jmp_e, pred}; read/write pointers carry an extra wrap bit; full = same index with opposite wrap, empty = equal pointers.
REQ-025 if_ready SHALL equal !full && !flush, with no bypass: full with a same-cycle resolve still gives if_ready=0.
REQ-026 An entry SHALL be written on an edge where rdy && if_valid && if_ready.
REQ-027 A resolve SHALL be accepted on an edge where rdy && ex_valid && !empty and SHALL pop the head entry.
REQ-028 An entry enqueued at an edge SHALL NOT be resolvable at that same edge.
REQ-029 Next PC values: correct_next = ex_taken ? ex_target : head.pc+4; predicted_next = head.jmp_e ? head.pred : head.pc+4; additions are modulo 2^AW.
REQ-030 Mispredict SHALL be predicted_next != correct_next; a taken branch with the right direction but the wrong target counts as a mispredict.
REQ-031 Every accepted resolve SHALL register on the next edge: upd_jmp_r=1, upd_addr_r=head.pc, upd_change_e=ex_taken, upd_target_addr=ex_target, upd_target_real=correct_next.
REQ-032 On a mispredicted resolve, the same edge SHALL set flush=1, set redirect_pc=correct_next, empty the FIFO, discard any same-cycle enqueue, and increment miss_cnt.
REQ-033 flush and upd_jmp_r SHALL be single-cycle pulses; deassert on the following edge unless a new resolve occurs.
REQ-034 ex_valid while flush=1 SHALL be ignored (wrong-path result).
REQ-035 err SHALL be set by ex_valid while empty (and flush=0), or by ex_pc != head.pc on an accepted resolve.
REQ-036 An ex_pc mismatch SHALL still pop and train using head.pc.
REQ-037 err SHALL clear only on reset.
REQ-038 With rdy=0, no enqueue, resolve, counter update or pulse deassertion SHALL occur.

Reset
REQ-039 While rst_n=0: pointers=0 (empty), if_ready=1, upd_jmp_r=0, flush=0, err=0, miss_cnt=0, all address outputs=0, upd_change_e=0.
REQ-040 Reset asserted mid-operation SHALL discard all entries immediately; the first enqueue is allowed on the first edge after release.

Verification
REQ-041 Enqueue {0x100, jmp_e=1, pred=0x80}, then resolve taken, target 0x80 -> next cycle upd_jmp_r=1, upd_addr_r=0x100, upd_change_e=1, upd_target_real=0x80; flush=0; miss_cnt=0.
REQ-042 Enqueue {0x200, jmp_e=1, pred=0x300}, then resolve not taken -> flush=1, redirect_pc=0x204, upd_change_e=0; FIFO empty; miss_cnt=1.
REQ-043 Enqueue {0x10, jmp_e=1, pred=0x40}, then resolve taken, target 0x44 -> flush=1, redirect_pc=0x44.
REQ-044 Enqueue 4 entries -> if_ready=0; resolve plus if_valid in the same cycle -> no write, count=3, if_ready=1 the next cycle.
REQ-045 Fill 3 entries, mispredict head while if_valid=1 -> FIFO empty, if_ready=0 during the flush cycle, ex_valid during flush ignored, err=0.
REQ-046 ex_valid with FIFO empty -> err=1 and held; rst_n pulse low mid-stream -> err=0, FIFO empty, outputs at reset values.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolver: queues fetch-time predictions, checks them against execute
// results in order, trains the predictor and raises a flush on mispredict.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          if_valid,
  input  logic [AW-1:0] if_pc,
  input  logic          if_jmp_e,
  input  logic [AW-1:0] if_pred,
  output logic          if_ready,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_pc,
  input  logic          ex_taken,
  input  logic [AW-1:0] ex_target,
  output logic          upd_jmp_r,
  output logic [AW-1:0] upd_addr_r,
  output logic          upd_change_e,
  output logic [AW-1:0] upd_target_addr,
  output logic [AW-1:0] upd_target_real,
  output logic          flush,
  output logic [AW-1:0] redirect_pc,
  output logic          err,
  output logic [31:0]   miss_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   PTR_ONE = 1;
  localparam logic [AW-1:0] INSN_BYTES = 4;

  // Entry storage; no reset needed since validity comes from the pointers.
  logic [AW-1:0]    r_pc_mem   [DEPTH];
  logic [AW-1:0]    r_pred_mem [DEPTH];
  logic [DEPTH-1:0] r_jmp_mem;

  logic [PW:0]   r_wptr, r_rptr;
  logic          r_upd_jmp;
  logic [AW-1:0] r_upd_addr;
  logic          r_upd_change;
  logic [AW-1:0] r_upd_target_addr;
  logic [AW-1:0] r_upd_target_real;
  logic          r_flush;
  logic [AW-1:0] r_redirect_pc;
  logic          r_err;
  logic [31:0]   r_miss_cnt;

  logic          w_empty, w_full;
  logic          w_enq, w_resolve, w_mispred, w_err_set;
  logic [AW-1:0] w_head_pc, w_head_pred, w_head_seq;
  logic          w_head_jmp;
  logic [AW-1:0] w_correct_next, w_predicted_next;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);

  assign w_head_pc   = r_pc_mem[r_rptr[PW-1:0]];
  assign w_head_pred = r_pred_mem[r_rptr[PW-1:0]];
  assign w_head_jmp  = r_jmp_mem[r_rptr[PW-1:0]];
  assign w_head_seq  = w_head_pc + INSN_BYTES;

  assign w_correct_next   = ex_taken   ? ex_target   : w_head_seq;
  assign w_predicted_next = w_head_jmp ? w_head_pred : w_head_seq;

  // No bypass: a full queue stays closed even if the head resolves this cycle.
  assign if_ready = !w_full && !r_flush;

  assign w_enq     = rdy && if_valid && if_ready;
  // Results arriving during a flush belong to the wrong path.
  assign w_resolve = rdy && ex_valid && !w_empty && !r_flush;
  assign w_mispred = w_resolve && (w_predicted_next != w_correct_next);
  assign w_err_set = rdy && ex_valid && !r_flush && (w_empty || (ex_pc != w_head_pc));

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wptr[PW-1:0]]   <= if_pc;
      r_pred_mem[r_wptr[PW-1:0]] <= if_pred;
      r_jmp_mem[r_wptr[PW-1:0]]  <= if_jmp_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (rdy) begin
      if (w_mispred) begin
        // Drop every queued entry and any same-cycle enqueue.
        r_rptr <= r_wptr;
      end else begin
        if (w_enq)     r_wptr <= r_wptr + PTR_ONE;
        if (w_resolve) r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_jmp         <= 1'b0;
      r_upd_addr        <= '0;
      r_upd_change      <= 1'b0;
      r_upd_target_addr <= '0;
      r_upd_target_real <= '0;
      r_flush           <= 1'b0;
      r_redirect_pc     <= '0;
      r_err             <= 1'b0;
      r_miss_cnt        <= '0;
    end else if (rdy) begin
      r_upd_jmp <= w_resolve;
      r_flush   <= w_mispred;
      if (w_resolve) begin
        r_upd_addr        <= w_head_pc;
        r_upd_change      <= ex_taken;
        r_upd_target_addr <= ex_target;
        r_upd_target_real <= w_correct_next;
      end
      if (w_mispred) begin
        r_redirect_pc <= w_correct_next;
        r_miss_cnt    <= r_miss_cnt + 32'd1;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign upd_jmp_r       = r_upd_jmp;
  assign upd_addr_r      = r_upd_addr;
  assign upd_change_e    = r_upd_change;
  assign upd_target_addr = r_upd_target_addr;
  assign upd_target_real = r_upd_target_real;
  assign flush           = r_flush;
  assign redirect_pc     = r_redirect_pc;
  assign err             = r_err;
  assign miss_cnt        = r_miss_cnt;

endmodule
